// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle for the 16-way round-robin arbiter.
// master: requesters (enable/req/done); slave: arbiter (grant/idx/valid/timeout).
interface rr_arbiter_16_if;
  logic        enable;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter, IDLE/GRANT FSM, hold limit with timeout pulse.
// Ports: clk, rst_n (async low), bus (rr_arbiter_16_if.slave).
module rr_arbiter_16 #(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter_16_if.slave  bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);

  state_t      state;
  logic [3:0]  ptr;
  logic [7:0]  hold_cnt;
  logic [15:0] grant_q;
  logic [3:0]  idx_q;
  logic        valid_q;
  logic        tmo_q;

  logic [31:0] dbl;
  logic [15:0] rot;
  logic [3:0]  off;
  logic [3:0]  win;
  logic        any;
  logic        cur;
  logic        at_lim;
  logic        rel;
  logic        hit;

  // Rotate so bit 0 is the pointer; lowest set bit is the winner.
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr;
    rot = dbl[15:0];
    off = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) off = 4'(i);
    end
    win = ptr + off;
    any = |bus.req;
  end

  always_comb begin
    cur    = bus.req[idx_q];
    at_lim = hold_cnt == LIM;
    rel    = bus.done | ~cur | ~bus.enable | at_lim;
    // Timeout only when the hold limit is the sole cause.
    hit    = at_lim & ~bus.done & cur & bus.enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.enable && any) begin
            state    <= GRANT;
            grant_q  <= 16'(1) << win;
            idx_q    <= win;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= idx_q + 4'd1;
            tmo_q   <= hit;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = tmo_q;

endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter MAX_HOLD, default 16, SHALL be the maximum number of consecutive cycles one grant is held; legal range is 2..255.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port enable, input, 1 bit: arbitration enable.
REQ-006 Port req, input, 16 bits: request vector, one bit per requester, any number set.
REQ-007 Port done, input, 1 bit: the current grantee releases the resource.
REQ-008 Port grant, output, 16 bits: registered one-hot grant, or all-zero.
REQ-009 Port grant_idx, output, 4 bits: binary index of the set grant bit.
REQ-010 Port grant_valid, output, 1 bit: high when grant is nonzero.
REQ-011 Port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 The rotating priority pointer ptr (4 bits) SHALL name the highest-priority requester; search order is ptr, ptr+1, ... 15, 0, ... ptr-1, with mod-16 wrap.
REQ-014 In IDLE with enable=1 and req!=0, the FSM SHALL select the first set req bit in search order, register it into grant/grant_idx at that edge, and enter GRANT.
- Latency: req sampled at edge N; grant visible after edge N.
REQ-015 In IDLE with enable=0 or req=0, the outputs SHALL stay at zero; done SHALL be ignored.
REQ-016 grant SHALL always be one-hot or zero.
- grant_idx SHALL equal the encoded position of the grant bit, and SHALL be 0 when grant=0.
- grant_valid SHALL equal the OR of grant.
REQ-017 hold_cnt (8 bits) SHALL load 0 on entry to GRANT and increment by 1 on each GRANT cycle that does not release.
REQ-018 In GRANT, a release SHALL occur at an edge where any of the following holds:
- done=1;
- req[grant_idx]=0;
- enable=0;
- hold_cnt==MAX_HOLD-1.
REQ-019 On release, at that edge:
- grant, grant_idx and grant_valid SHALL clear;
- ptr SHALL become grant_idx+1 mod 16 (15 wraps to 0);
- the FSM SHALL enter IDLE.
REQ-020 This gives at least one IDLE turnaround cycle between consecutive grants.
REQ-021 timeout SHALL be registered high for exactly the one cycle after a release caused only by the hold limit, i.e. done=0, req[grant_idx]=1 and enable=1.
REQ-022 Simultaneous release causes SHALL produce a single release; timeout SHALL be asserted only under the condition in REQ-021.
REQ-023 Changes to req bits other than grant_idx during GRANT SHALL NOT affect the current grant.
REQ-024 A grant SHALL last at most MAX_HOLD cycles and at least 1 cycle.

Reset
REQ-025 While rst_n=0, asynchronously and without a clock edge, the block SHALL force:
- grant=0, grant_idx=0, grant_valid=0, timeout=0;
- hold_cnt=0, ptr=0, FSM=IDLE.
REQ-026 Assertion of reset mid-grant SHALL drop the grant immediately.
REQ-027 After reset deassertion, the first arbitration SHALL be evaluated at the first rising edge with rst_n=1.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset: rst_n=0, req=16'hFFFF, enable=1 -> grant=0, grant_idx=0, grant_valid=0, timeout=0.
- Single request: req=16'h0020, enable=1 -> one edge later grant=16'h0020, grant_idx=5, grant_valid=1. Then done=1 for one cycle -> grant=0 after that edge.
- Round robin: req=16'h8001 held, done pulsed each grant cycle -> grant_idx sequence 0,15,0,15, with one idle cycle between grants.
- Pointer wrap: winner 15 released, then req=16'h0003 -> grant_idx 0 first, then 1.
- Hold limit: MAX_HOLD=4, req=16'h0101, done=0 -> grant_idx=0 high for exactly 4 cycles, then timeout=1 for one cycle with grant=0, then grant_idx=8.
- Async reset mid-grant: rst_n falls between edges while grant_valid=1 -> all outputs 0 before the next edge; after release, req=16'h8001 -> grant_idx=0.
